// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Registers the granted operands, waits ALU_LAT cycles, then offers the tagged result.
//
// state | meaning
// IDLE  | no operation in flight; grant offered to a valid requester
// WAIT  | operands held on the ALU; latency timer counting down
// RESP  | result captured; waiting for the consumer to accept it
module alu_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [3:0]           req_cond,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_cond,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_out,
    output logic                 rsp_carry,
    output logic                 rsp_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    logic [1:0]       state;
    logic             ptr;
    logic [LAT_W-1:0] wait_cnt;

    logic             grant_vld;
    logic             grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_cond;

    // The pointer requester wins when valid; otherwise the other one may take the slot.
    always_comb begin
        grant_vld = 1'b0;
        grant     = ptr;
        if (rst_n && state == IDLE) begin
            if (req_valid[ptr]) begin
                grant_vld = 1'b1;
                grant     = ptr;
            end else if (req_valid[~ptr]) begin
                grant_vld = 1'b1;
                grant     = ~ptr;
            end
        end
    end

    assign req_ready = grant_vld ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign sel_a     = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b     = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign sel_cond  = grant ? req_cond[3:2] : req_cond[1:0];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cond  <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        alu_a    <= sel_a;
                        alu_b    <= sel_b;
                        alu_cond <= sel_cond;
                        rsp_id   <= grant;
                        ptr      <= ~grant;
                        wait_cnt <= LAT_W'(ALU_LAT);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Terminal count of 1 lands the capture exactly ALU_LAT edges after grant.
                    wait_cnt <= wait_cnt - LAT_W'(1);
                    if (wait_cnt == LAT_W'(1)) begin
                        rsp_out   <= alu_out;
                        rsp_carry <= alu_carry;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: two instances (ALU_LAT=1/CNT_W=16 and ALU_LAT=3/CNT_W=4)
// on shared stimulus, each watched by a transaction-level reference model.
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_cond;
    logic        rsp_ready;

    logic [1:0]  req_ready [2];
    logic [7:0]  alu_a     [2];
    logic [7:0]  alu_b     [2];
    logic [1:0]  alu_cond  [2];
    logic [7:0]  alu_out   [2];
    logic        alu_carry [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_out   [2];
    logic        rsp_carry [2];
    logic        rsp_id    [2];
    logic        busy      [2];
    logic [15:0] op_count_x [2];
    logic [3:0]  op_count1;

    int n_cmp = 0;
    int n_mis = 0;

    // Stand-in for the shared ALU: {carry, out}
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] c);
        case (c)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {(a < b), 8'(a - b)};
            2'b10:   return {(a == b), a ^ b};
            default: return {$onehot(a), a & b};
        endcase
    endfunction

    task automatic chk_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    alu_req_arbiter #(.WIDTH(8), .ALU_LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_a(req_a), .req_b(req_b), .req_cond(req_cond),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_cond(alu_cond[0]),
        .alu_out(alu_out[0]), .alu_carry(alu_carry[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_out(rsp_out[0]),
        .rsp_carry(rsp_carry[0]), .rsp_id(rsp_id[0]), .busy(busy[0]),
        .op_count(op_count_x[0])
    );

    alu_req_arbiter #(.WIDTH(8), .ALU_LAT(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_a(req_a), .req_b(req_b), .req_cond(req_cond),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_cond(alu_cond[1]),
        .alu_out(alu_out[1]), .alu_carry(alu_carry[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_out(rsp_out[1]),
        .rsp_carry(rsp_carry[1]), .rsp_id(rsp_id[1]), .busy(busy[1]),
        .op_count(op_count1)
    );

    assign op_count_x[1] = {12'h000, op_count1};

    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int          LAT  = (g == 0) ? 1 : 3;
        localparam logic [15:0] MASK = (g == 0) ? 16'hFFFF : 16'h000F;

        assign {alu_carry[g], alu_out[g]} = alu_fn(alu_a[g], alu_b[g], alu_cond[g]);

        // Model: one op in flight, response due LAT+1 samples after the grant sample.
        bit          out_st = 1'b0;
        int          ptr    = 0;
        int          cyc    = 0;
        int          hs_cyc = 0;
        logic [7:0]  e_a    = '0;
        logic [7:0]  e_b    = '0;
        logic [1:0]  e_cond = '0;
        logic        e_id   = 1'b0;
        logic [8:0]  e_r    = '0;
        logic [15:0] e_cnt  = '0;

        always @(negedge clk) begin : mon
            logic [1:0] er;
            int         gr;
            logic       ev;
            cyc = cyc + 1;
            if (!rst_n) begin
                chk_eq($sformatf("d%0d_rst_ready", g), 16'(req_ready[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_alu_a", g), 16'(alu_a[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_alu_b", g), 16'(alu_b[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_alu_cond", g), 16'(alu_cond[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_rsp_valid", g), 16'(rsp_valid[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_rsp_out", g), 16'(rsp_out[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_rsp_carry", g), 16'(rsp_carry[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_rsp_id", g), 16'(rsp_id[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_busy", g), 16'(busy[g]), 16'd0);
                chk_eq($sformatf("d%0d_rst_count", g), op_count_x[g], 16'd0);
                out_st = 1'b0; ptr = 0; e_a = '0; e_b = '0; e_cond = '0; e_cnt = '0;
            end else begin
                gr = -1;
                er = 2'b00;
                if (!out_st) begin
                    if (req_valid[ptr])          gr = ptr;
                    else if (req_valid[1 - ptr]) gr = 1 - ptr;
                end
                if (gr >= 0) er = 2'b01 << gr;
                ev = out_st && (cyc - hs_cyc > LAT);

                chk_eq($sformatf("d%0d_req_ready", g), 16'(req_ready[g]), 16'(er));
                chk_eq($sformatf("d%0d_busy", g), 16'(busy[g]), 16'(out_st));
                chk_eq($sformatf("d%0d_rsp_valid", g), 16'(rsp_valid[g]), 16'(ev));
                chk_eq($sformatf("d%0d_alu_a", g), 16'(alu_a[g]), 16'(e_a));
                chk_eq($sformatf("d%0d_alu_b", g), 16'(alu_b[g]), 16'(e_b));
                chk_eq($sformatf("d%0d_alu_cond", g), 16'(alu_cond[g]), 16'(e_cond));
                chk_eq($sformatf("d%0d_op_count", g), op_count_x[g], e_cnt & MASK);
                if (ev) begin
                    chk_eq($sformatf("d%0d_rsp_out", g), 16'(rsp_out[g]), 16'(e_r[7:0]));
                    chk_eq($sformatf("d%0d_rsp_carry", g), 16'(rsp_carry[g]), 16'(e_r[8]));
                    chk_eq($sformatf("d%0d_rsp_id", g), 16'(rsp_id[g]), 16'(e_id));
                end

                if (ev && rsp_ready) begin
                    out_st = 1'b0;
                    e_cnt  = e_cnt + 16'd1;
                end
                if (gr >= 0) begin
                    out_st = 1'b1;
                    hs_cyc = cyc;
                    e_a    = req_a[gr*8 +: 8];
                    e_b    = req_b[gr*8 +: 8];
                    e_cond = req_cond[gr*2 +: 2];
                    e_id   = (gr == 1);
                    ptr    = 1 - gr;
                    e_r    = alu_fn(e_a, e_b, e_cond);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [1:0] c0, input logic [7:0] a1, input logic [7:0] b1,
                         input logic [1:0] c1);
        @(posedge clk); #1;
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_cond  = {c1, c0};
    endtask

    task automatic wait_hs0();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[0] != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("hs_timeout", 16'(ok), 16'd1);
    endtask

    task automatic wait_rsp0();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("rsp_timeout", 16'(ok), 16'd1);
    endtask

    task automatic one_op0(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [1:0] c0, input logic [7:0] a1, input logic [7:0] b1,
                           input logic [1:0] c1);
        drive(v, a0, b0, c0, a1, b1, c1);
        wait_hs0();
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp0();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic        ids [4];
        int          n_ids;
        logic [15:0] cnt0;

        rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_cond = '0;
        rsp_ready = 1'b1;
        do_reset();

        // Basic add, then add with carry out
        one_op0(2'b01, 8'h06, 8'h60, 2'b00, 8'h00, 8'h00, 2'b00);
        chk_eq("t1_out", 16'(rsp_out[0]), 16'h0066);
        chk_eq("t1_carry", 16'(rsp_carry[0]), 16'd0);
        chk_eq("t1_id", 16'(rsp_id[0]), 16'd0);
        @(negedge clk);
        chk_eq("t1_count", op_count_x[0], 16'd1);

        one_op0(2'b01, 8'hFF, 8'h01, 2'b00, 8'h00, 8'h00, 2'b00);
        chk_eq("t2_out", 16'(rsp_out[0]), 16'h0000);
        chk_eq("t2_carry", 16'(rsp_carry[0]), 16'd1);

        // Both requesters held from reset: alternating ownership
        do_reset();
        drive(2'b11, 8'h11, 8'h22, 2'b01, 8'h33, 8'h33, 2'b10);
        n_ids = 0;
        for (int i = 0; i < 60 && n_ids < 4; i++) begin
            @(negedge clk);
            if (rsp_valid[0] && rsp_ready) begin
                ids[n_ids] = rsp_id[0];
                n_ids++;
            end
        end
        chk_eq("t3_nrsp", 16'(n_ids), 16'd4);
        chk_eq("t3_id0", 16'(ids[0]), 16'd0);
        chk_eq("t3_id1", 16'(ids[1]), 16'd1);
        chk_eq("t3_id2", 16'(ids[2]), 16'd0);
        chk_eq("t3_id3", 16'(ids[3]), 16'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (8) @(negedge clk);

        // Consumer stalls in RESP
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        one_op0(2'b01, 8'hAA, 8'h55, 2'b01, 8'h00, 8'h00, 2'b00);
        cnt0 = op_count_x[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("t4_busy", 16'(busy[0]), 16'd1);
            chk_eq("t4_ready", 16'(req_ready[0]), 16'd0);
            chk_eq("t4_count", op_count_x[0], cnt0);
            chk_eq("t4_out", 16'(rsp_out[0]), 16'h0055);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_eq("t4_count_acc", op_count_x[0], cnt0 + 16'd1);
        repeat (8) @(negedge clk);

        // Reset while the op waits on the ALU
        drive(2'b10, 8'h00, 8'h00, 2'b00, 8'h12, 8'h34, 2'b00);
        wait_hs0();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk_eq("t5_busy", 16'(busy[0]), 16'd0);
        chk_eq("t5_alu_a", 16'(alu_a[0]), 16'd0);
        chk_eq("t5_rsp_valid", 16'(rsp_valid[0]), 16'd0);
        chk_eq("t5_count", op_count_x[0], 16'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_eq("t5_no_rsp", 16'(rsp_valid[0]), 16'd0);
        end
        one_op0(2'b11, 8'h21, 8'h43, 2'b10, 8'h77, 8'h77, 2'b11);
        chk_eq("t5_id", 16'(rsp_id[0]), 16'd0);
        chk_eq("t5_out", 16'(rsp_out[0]), 16'h0062);

        // Randomised traffic, including valid drops and consumer stalls
        for (int i = 0; i < 900; i++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom_range(0, 3));
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_cond  = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
